// File: rtl/cpu_bus_burst_rw.sv
// Single/burst read-write sequencer between the CPU function sequencer and the motherboard bus.
// Optional feature: define CPU_BUS_RW_TIMEOUT_EN to abort a beat after TIMEOUT_CYCLES without bus_ack.
module cpu_bus_burst_rw #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int LEN_WIDTH     = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [WORD_WIDTH-1:0] bus_wdata,
  output logic                  bus_rd,
  output logic                  bus_wr,
  input  logic                  bus_ack,
  input  logic [WORD_WIDTH-1:0] bus_rdata
);

`ifdef CPU_BUS_RW_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STROBE, S_DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST);
  localparam int                   TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic                  r_write;
  logic                  r_req_ready;
  logic [WORD_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [WORD_WIDTH-1:0] r_bus_wdata;
  logic                  r_bus_rd;
  logic                  r_bus_wr;
  logic [TO_W-1:0]       r_to_cnt;

  logic                  w_strobe;
  logic                  w_last;
  logic                  w_timeout;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [ADDR_WIDTH-1:0] w_beat_addr;

  assign w_strobe    = r_bus_rd | r_bus_wr;
  assign w_len       = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  assign w_last      = (r_beat == r_len - LEN_WIDTH'(1));
  assign w_beat_addr = r_addr + ADDR_WIDTH'(r_beat);
  // With the feature off this is constant 0, so err and the wait counter fold away.
  assign w_timeout   = TIMEOUT_EN && (r_to_cnt == TO_LAST);

  assign req_ready = r_req_ready;
  // wr_ready is a same-cycle handshake: high exactly in the cycle wr_data is captured.
  assign wr_ready  = (r_state == S_FETCH) && wr_valid;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign err       = r_err;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_rd    = r_bus_rd;
  assign bus_wr    = r_bus_wr;

  // Per-beat ack wait counter; cleared whenever the strobe is low, i.e. between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_to_cnt <= '0;
    else if (w_strobe && !bus_ack) r_to_cnt <= r_to_cnt + TO_W'(1);
    else                           r_to_cnt <= '0;
  end

  // NOTE: all state uses non-blocking assignments under an async reset, so a reset
  // mid-burst drops the strobes immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_write     <= 1'b0;
      r_req_ready <= 1'b1;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_rd    <= 1'b0;
      r_bus_wr    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_len       <= w_len;
            r_write     <= req_write;
            r_beat      <= '0;
            if (w_len == '0) begin
              r_state <= S_DONE;
            end else if (req_write) begin
              r_state <= S_FETCH;
            end else begin
              r_state    <= S_STROBE;
              r_bus_rd   <= 1'b1;
              r_bus_addr <= req_addr;
            end
          end
        end
        S_FETCH: begin
          if (wr_valid) begin
            r_bus_wdata <= wr_data;
            r_bus_wr    <= 1'b1;
            r_bus_addr  <= w_beat_addr;
            r_state     <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (!w_strobe) begin
            // Re-raise after the one-cycle gap that follows every acknowledged beat.
            r_bus_rd   <= !r_write;
            r_bus_wr   <= r_write;
            r_bus_addr <= w_beat_addr;
          end else if (bus_ack) begin
            r_bus_rd <= 1'b0;
            r_bus_wr <= 1'b0;
            r_beat   <= r_beat + LEN_WIDTH'(1);
            if (!r_write) begin
              r_rd_data  <= bus_rdata;
              r_rd_valid <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (r_write) begin
              r_state <= S_FETCH;
            end
          end else if (w_timeout) begin
            r_bus_rd <= 1'b0;
            r_bus_wr <= 1'b0;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
          end
        end
        S_DONE: begin
          // Bus paths enter with done already set; a zero-length request spends one
          // extra cycle here before raising it.
          if (r_done) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_burst_rw.sv
// Scoreboard bench for cpu_bus_burst_rw: stimulus queues expected beats/reads/dones,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cpu_bus_burst_rw;
  localparam int WW = 32;
  localparam int AW = 16;
  localparam int LW = 4;
`ifdef CPU_BUS_RW_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [WW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic [AW-1:0] bus_addr;
  logic [WW-1:0] bus_wdata;
  logic          bus_rd;
  logic          bus_wr;
  logic          bus_ack = 1'b0;
  logic [WW-1:0] bus_rdata = '0;

  cpu_bus_burst_rw #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MAX_BURST(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [AW-1:0] addr; logic [WW-1:0] wdata; int hi; } beat_t;
  typedef struct { logic err; int lat; } done_t;

  beat_t         exp_bus[$];
  logic [WW-1:0] exp_rd[$];
  done_t         exp_done[$];
  logic [WW-1:0] wr_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0, rises = 0, wr_cnt = 0, err_seen = 0;
  int ack_delay = 1;
  bit ack_en = 1'b1, force_ack = 1'b0, wr_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] rdata_of(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
  endfunction

  always @(posedge clk) cyc++;

  // Bus slave: acks once the strobe has been high for ack_delay sampled cycles.
  int resp_hc = 0;
  always @(negedge clk) resp_hc = (bus_rd || bus_wr) ? resp_hc + 1 : 0;
  always @(posedge clk) begin
    #1;
    bus_ack   = force_ack || (ack_en && (bus_rd || bus_wr) && resp_hc >= ack_delay);
    bus_rdata = bus_ack ? rdata_of(bus_addr) : '0;
  end

  // Write-data source: presents the head of wr_q, pops after each handshake.
  bit wr_hs = 1'b0;
  always @(negedge clk) wr_hs = wr_valid && wr_ready;
  always @(posedge clk) begin
    #1;
    if (wr_hs && wr_q.size() > 0) void'(wr_q.pop_front());
    wr_valid = wr_en && (wr_q.size() > 0);
    wr_data  = (wr_q.size() > 0) ? wr_q[0] : '0;
  end

  bit prev_strobe = 1'b0;
  int hi_cnt = 0, hi_exp = 0;
  always @(negedge clk) begin : monitor
    beat_t b;
    done_t d;
    logic  stb;
    stb = bus_rd || bus_wr;
    if (!rst_n) begin
      prev_strobe = 1'b0;
      hi_cnt = 0;
      hi_exp = 0;
      exp_bus.delete();
      exp_rd.delete();
      exp_done.delete();
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (wr_ready) wr_cnt++;
      if (err) err_seen++;
      if (stb && !prev_strobe) begin
        rises++;
        hi_cnt = 1;
        check("beat_expected", exp_bus.size() > 0, 1);
        if (exp_bus.size() > 0) begin
          b = exp_bus.pop_front();
          hi_exp = b.hi;
          check("beat_rd_wr_exclusive", bus_rd && bus_wr, 0);
          check("beat_dir_wr", bus_wr, b.wr);
          check("beat_addr", bus_addr, b.addr);
          if (b.wr) check("beat_wdata", bus_wdata, b.wdata);
        end else begin
          hi_exp = 0;
        end
      end else if (stb) begin
        hi_cnt++;
      end else if (prev_strobe && hi_exp != 0) begin
        check("strobe_high_cycles", hi_cnt, hi_exp);
      end
      if (rd_valid) begin
        check("rd_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        check("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) begin
          d = exp_done.pop_front();
          check("done_err", err, d.err);
          if (d.lat >= 0) check("done_latency", cyc - acc_cyc, d.lat);
        end
      end
      prev_strobe = stb;
    end
  end

  task automatic send_req(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_accepted", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_done.size() + exp_bus.size() + exp_rd.size()) > 0 && n < budget) begin
      @(negedge clk); n++;
    end
    check({name, "_drained"}, exp_done.size() + exp_bus.size() + exp_rd.size(), 0);
  endtask

  task automatic push_read(input logic [AW-1:0] a, input int hi);
    exp_bus.push_back('{1'b0, a, '0, hi});
    exp_rd.push_back(rdata_of(a));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int w0, r0, n;
    logic [AW-1:0] a;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_strobes", {bus_rd, bus_wr}, 0);
    check("rst_pulses", {done, err, rd_valid, wr_ready}, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_bus_addr_wdata", {bus_addr, bus_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);

    // Single read: strobe cycles 1-2, rd_valid and done at cycle 3.
    exp_bus.push_back('{1'b0, 16'h0010, '0, 2});
    exp_rd.push_back(32'hDEADBEEF);
    exp_done.push_back('{1'b0, 3});
    send_req(1'b0, 16'h0010, 4'd1);
    drain("single_read", 20);
    @(negedge clk);
    check("req_ready_after_done", req_ready, 1);

    // Four-beat write burst.
    w0 = wr_cnt;
    for (int i = 1; i <= 4; i++) begin
      wr_q.push_back(WW'(i));
      exp_bus.push_back('{1'b1, 16'h0100 + AW'(i - 1), WW'(i), 2});
    end
    exp_done.push_back('{1'b0, -1});
    send_req(1'b1, 16'h0100, 4'd4);
    drain("write_burst", 60);
    check("write_burst_wr_ready_pulses", wr_cnt - w0, 4);

    // Read burst wrapping the address space.
    exp_bus.push_back('{1'b0, 16'hFFFE, '0, 2});
    exp_bus.push_back('{1'b0, 16'hFFFF, '0, 2});
    exp_bus.push_back('{1'b0, 16'h0000, '0, 2});
    exp_rd.push_back(32'h0001FFFE);
    exp_rd.push_back(32'h0000FFFF);
    exp_rd.push_back(32'hFFFF0000);
    exp_done.push_back('{1'b0, -1});
    send_req(1'b0, 16'hFFFE, 4'd3);
    drain("wrap_read", 40);

    // Zero-length read and write: done two cycles after accept, no bus activity.
    w0 = wr_cnt;
    exp_done.push_back('{1'b0, 2});
    send_req(1'b0, 16'h0700, 4'd0);
    drain("len0_read", 10);
    exp_done.push_back('{1'b0, 2});
    send_req(1'b1, 16'h0700, 4'd0);
    drain("len0_write", 10);
    check("len0_no_wr_ready", wr_cnt - w0, 0);

    // Write stalled on wr_valid, with a spurious ack while no strobe is up.
    wr_en = 1'b0;
    wr_q.push_back(32'h000000A1);
    wr_q.push_back(32'h000000A2);
    r0 = rises;
    send_req(1'b1, 16'h0600, 4'd2);
    force_ack = 1'b1;
    repeat (6) @(negedge clk);
    check("stall_no_strobe", rises - r0, 0);
    check("stall_bus_wr_low", bus_wr, 0);
    force_ack = 1'b0;
    exp_bus.push_back('{1'b1, 16'h0600, 32'h000000A1, 2});
    exp_bus.push_back('{1'b1, 16'h0601, 32'h000000A2, 2});
    exp_done.push_back('{1'b0, -1});
    @(negedge clk);
    wr_en = 1'b1;
    drain("stall_write", 40);

    // Oversized length clamps to MAX_BURST beats.
    for (int i = 0; i < 8; i++) begin
      a = 16'h0200 + AW'(i);
      push_read(a, 2);
    end
    exp_done.push_back('{1'b0, -1});
    send_req(1'b0, 16'h0200, 4'd12);
    drain("clamp_read", 80);

    // Reset in the middle of beat 2 of a 4-beat read.
    ack_delay = 3;
    for (int i = 0; i < 4; i++) push_read(16'h0300 + AW'(i), 4);
    exp_done.push_back('{1'b0, -1});
    r0 = rises;
    send_req(1'b0, 16'h0300, 4'd4);
    n = 0;
    while (rises - r0 < 2 && n < 100) begin @(negedge clk); n++; end
    check("rst_beat2_reached", rises - r0, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midburst_rst_bus_rd", bus_rd, 0);
    check("midburst_rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 1;
    @(negedge clk);
    check("midburst_rst_req_ready", req_ready, 1);
    push_read(16'h0400, 2);
    push_read(16'h0401, 2);
    exp_done.push_back('{1'b0, -1});
    send_req(1'b0, 16'h0400, 4'd2);
    drain("after_rst_read", 30);

`ifdef CPU_BUS_RW_TIMEOUT_EN
    // No ack: strobe high TO cycles, then done+err together; second beat abandoned.
    ack_en = 1'b0;
    exp_bus.push_back('{1'b0, 16'h0500, '0, TO});
    exp_done.push_back('{1'b1, TO + 1});
    send_req(1'b0, 16'h0500, 4'd2);
    drain("timeout_read", 40);
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    check("timeout_strobe_dropped", {bus_rd, bus_wr}, 0);
`else
    // No ack: strobe held indefinitely and err never rises.
    ack_en = 1'b0;
    push_read(16'h0500, 0);
    exp_done.push_back('{1'b0, -1});
    send_req(1'b0, 16'h0500, 4'd1);
    repeat (300) @(negedge clk);
    check("no_timeout_strobe_held", bus_rd, 1);
    check("no_timeout_err", err_seen, 0);
    ack_en = 1'b1;
    drain("no_timeout_read", 20);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_bus_burst_rw.md
Name: cpu_bus_burst_rw

Overview:
Parametrised successor to the CPU read/write function states. It executes single or burst read/write transactions between the CPU core and the motherboard bus. The CPU core issues one request (address, length, direction) and the block sequences the bus strobe/acknowledge handshake beat by beat. It returns read data, consumes write data, and signals completion. It sits between the CPU function sequencer and the mobo control/status interface.

Parameters:
WORD_WIDTH, 32, data width of bus and CPU data ports
ADDR_WIDTH, 16, bus address width; word-addressed
MAX_BURST, 8, maximum beats per request; LEN_WIDTH = clog2(MAX_BURST+1)
TIMEOUT_CYCLES, 255, ack wait limit per beat; used only with the optional feature

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  block can accept request (IDLE only)
req_write  in  1  1=write burst, 0=read burst
req_addr  in  ADDR_WIDTH  start word address
req_len  in  LEN_WIDTH  beat count, 0..MAX_BURST
wr_data  in  WORD_WIDTH  write data for current beat
wr_valid  in  1  wr_data valid
wr_ready  out  1  pulse: wr_data captured this cycle
rd_data  out  WORD_WIDTH  read data of last completed beat
rd_valid  out  1  pulse: rd_data valid
done  out  1  pulse: request finished
err  out  1  pulse with done: request aborted
bus_addr  out  ADDR_WIDTH  mobo address
bus_wdata  out  WORD_WIDTH  mobo write data
bus_rd  out  1  mobo read strobe
bus_wr  out  1  mobo write strobe
bus_ack  in  1  mobo beat acknowledge
bus_rdata  in  WORD_WIDTH  mobo read data, valid with bus_ack

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except req_ready=1. Beat counter, latched address and data registers 0. Reset mid-burst aborts immediately: strobes drop asynchronously, no done.
- States: IDLE, FETCH (write only: wait for wr_valid), STROBE, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr, len, write and clear beat counter. len=0 -> DONE with no bus activity. len>MAX_BURST is clamped to MAX_BURST. Otherwise go to FETCH (write) or STROBE (read).
- FETCH: when wr_valid=1, capture wr_data into bus_wdata, pulse wr_ready for 1 cycle, go to STROBE. Strobes stay low while waiting.
- STROBE: bus_addr = latched addr + beat, wrapping mod 2^ADDR_WIDTH. bus_rd or bus_wr is held high until bus_ack is sampled high. On ack:
  - Drop the strobe next cycle.
  - Read: register bus_rdata into rd_data and pulse rd_valid for 1 cycle.
  - Increment beat. If beat==len-1, go to DONE; else go to FETCH (write) or STROBE (read).
  - Strobe is deasserted for at least 1 cycle between beats.
- bus_ack while no strobe is active: ignored.
- DONE: done=1 for exactly 1 cycle, then IDLE. req_ready returns to 1 the cycle after done.
- Latency: single read, ack returned the cycle after strobe rises. Accept at cycle 0, bus_rd high cycles 1-2, ack at cycle 2, rd_valid and done at cycle 3.
- bus_rd and bus_wr are never high simultaneously. Only one request is outstanding at a time.

Optional Feature:
CPU_BUS_RW_TIMEOUT_EN:
- Defined: a per-beat counter runs while a strobe is high. If TIMEOUT_CYCLES elapse without bus_ack, the strobe drops, remaining beats are abandoned, and DONE asserts done=1 and err=1 together. The counter resets on each new beat.
- Undefined: STROBE waits indefinitely and err is tied to 0.

Test Plan:
- Single read at addr 0x0010, len=1, ack 1 cycle after strobe with bus_rdata=0xDEADBEEF -> bus_rd high 2 cycles, rd_data=0xDEADBEEF with rd_valid at cycle 3, done at cycle 3, err=0.
- Write burst addr 0x0100, len=4, wr_data 1..4 with wr_valid always high -> bus_wr beats at 0x0100..0x0103 with bus_wdata 1..4, 4 wr_ready pulses, strobe low ≥1 cycle between beats, one done.
- Read burst addr 0xFFFE, len=3 -> bus_addr sequence 0xFFFE, 0xFFFF, 0x0000; 3 rd_valid pulses.
- len=0 request -> done 2 cycles after accept, no bus_rd/bus_wr activity. wr_valid held low during a write -> strobe stays low, no hang once wr_valid rises.
- Assert rst_n=0 mid-way through beat 2 of a 4-beat read -> bus_rd=0 immediately, no done. After release: req_ready=1, and a new request completes normally.
- With CPU_BUS_RW_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ack never asserted -> strobe drops after 4 cycles, done=1 and err=1 in the same cycle. Without the macro -> strobe held, err never 1.
